n64_poll_sequencer: RTL

- Host-side sequencer for the N64 controller single-wire link.
- On request, drives the poll command (0x01 plus stop bit) onto the open-drain data line, then captures the 32-bit controller response.
- All bit timing comes from one internal descending timer: loadable, counts to 0, flags empty.
- Sits between the pad (external open-drain buffer) and the button-consumer logic.

---
 rtl/n64_poll_sequencer_if.sv | 21 ++
 rtl/n64_poll_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/n64_poll_sequencer_if.sv
// Pin-level bundle between the N64 poll sequencer, the pad buffer and the button consumer.
// slave = sequencer side, master = surrounding logic.
interface n64_poll_sequencer_if;
   logic        start;
   logic        data_in;
   logic        data_oe;
   logic        busy;
   logic        valid;
   logic        timeout_err;
   logic [31:0] buttons;

   modport master (
      output start, data_in,
      input  data_oe, busy, valid, timeout_err, buttons
   );

   modport slave (
      input  start, data_in,
      output data_oe, busy, valid, timeout_err, buttons
   );
endinterface

// File: rtl/n64_poll_sequencer.sv
// Host-side N64 controller poll sequencer: sends 0x01 + stop, captures the 32-bit reply.
// Optional AUTO_POLL_EN: free-running period counter issues polls without an external start.
module n64_poll_sequencer #(
   parameter int unsigned T_US       = 12,
   parameter int unsigned TIMEOUT_US = 200,
   parameter int unsigned GUARD_US   = 10
`ifdef AUTO_POLL_EN
  ,parameter int unsigned POLL_PERIOD_US = 16667
`endif
) (
   input logic                 clk,
   input logic                 reset,
   n64_poll_sequencer_if.slave bus
);

   localparam int unsigned LD_TIMEOUT = TIMEOUT_US * T_US;
   localparam int unsigned LD_GUARD   = GUARD_US * T_US;
   localparam int unsigned LD_MAX_A   = (LD_TIMEOUT > LD_GUARD) ? LD_TIMEOUT : LD_GUARD;
   localparam int unsigned LD_MAX     = (LD_MAX_A > 3 * T_US) ? LD_MAX_A : 3 * T_US;
   localparam int unsigned TW         = $clog2(LD_MAX) + 1;

   typedef enum logic [3:0] {
      IDLE,
      TX_LOW,
      TX_HIGH,
      TX_STOP,
      RX_WAIT_FALL,
      RX_SAMPLE,
      RX_WAIT_RISE,
      GUARD,
      ABORT
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [TW-1:0] r_timer;
   logic [TW-1:0] w_load;
   logic          w_expired;
   logic          w_start;
   logic          w_fall;
   logic          r_meta;
   logic          r_sync;
   logic          r_prev;
   logic [2:0]    r_txbit;
   logic [5:0]    r_cnt;
   logic [31:0]   r_shift;
   logic [31:0]   r_buttons;
   logic          r_valid;

   function automatic logic [TW-1:0] ld(input int unsigned n);
      return TW'(n - 1);
   endfunction

`ifdef AUTO_POLL_EN
   localparam int unsigned PERIOD = POLL_PERIOD_US * T_US;
   localparam int unsigned PW     = $clog2(PERIOD + 1);

   logic [PW-1:0] r_period;
   logic          w_tick;

   assign w_tick = (r_period == PW'(PERIOD - 1));

   always_ff @(posedge clk) begin
      if (reset)       r_period <= '0;
      else if (w_tick) r_period <= '0;
      else             r_period <= r_period + 1'b1;
   end

   assign w_start = bus.start | w_tick;
`else
   assign w_start = bus.start;
`endif

   assign w_expired = (r_timer == '0);
   assign w_fall    = r_prev & ~r_sync;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // A '1' bit has already risen by the sample point, so RX_WAIT_RISE waits on the released level.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:         if (w_start && !r_valid) w_next = TX_LOW;
         TX_LOW:       if (w_expired) w_next = TX_HIGH;
         TX_HIGH:      if (w_expired) w_next = (r_txbit == 3'd7) ? TX_STOP : TX_LOW;
         TX_STOP:      if (w_expired) w_next = RX_WAIT_FALL;
         RX_WAIT_FALL: if (w_fall) w_next = RX_SAMPLE;
                       else if (w_expired) w_next = ABORT;
         RX_SAMPLE:    if (w_expired) w_next = RX_WAIT_RISE;
         RX_WAIT_RISE: if (r_sync) w_next = (r_cnt == 6'd32) ? GUARD : RX_WAIT_FALL;
                       else if (w_expired) w_next = ABORT;
         GUARD:        if (w_expired) w_next = IDLE;
         ABORT:        w_next = IDLE;
         default:      w_next = IDLE;
      endcase

      w_load = '0;
      case (w_next)
         TX_LOW:       w_load = (r_state == TX_HIGH && r_txbit == 3'd6) ? ld(T_US) : ld(3 * T_US);
         TX_HIGH:      w_load = (r_txbit == 3'd7) ? ld(3 * T_US) : ld(T_US);
         TX_STOP:      w_load = ld(T_US);
         RX_WAIT_FALL: w_load = ld(LD_TIMEOUT);
         RX_SAMPLE:    w_load = ld(2 * T_US);
         RX_WAIT_RISE: w_load = ld(LD_TIMEOUT);
         GUARD:        w_load = ld(LD_GUARD);
         default:      w_load = '0;
      endcase
   end

   always_comb begin
      bus.data_oe     = 1'b0;
      bus.timeout_err = 1'b0;
      bus.busy        = (r_state != IDLE) || r_valid;
      case (r_state)
         TX_LOW, TX_STOP: bus.data_oe     = 1'b1;
         ABORT:           bus.timeout_err = 1'b1;
         default:         ;
      endcase
   end

   assign bus.valid   = r_valid;
   assign bus.buttons = r_buttons;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_timer   <= '0;
         r_meta    <= 1'b1;
         r_sync    <= 1'b1;
         r_prev    <= 1'b1;
         r_txbit   <= '0;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_buttons <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_meta  <= bus.data_in;
         r_sync  <= r_meta;
         r_prev  <= r_sync;
         r_valid <= 1'b0;

         if (w_next != r_state) r_timer <= w_load;
         else if (!w_expired)   r_timer <= r_timer - 1'b1;

         if (r_state == IDLE)                     r_txbit <= '0;
         else if (r_state == TX_HIGH && w_expired) r_txbit <= r_txbit + 3'd1;

         if (r_state == IDLE && w_next == TX_LOW) begin
            r_shift <= '0;
            r_cnt   <= '0;
         end else if (r_state == RX_SAMPLE && w_expired) begin
            r_shift <= {r_shift[30:0], r_sync};
            if (r_cnt != '1) r_cnt <= r_cnt + 6'd1;
         end

         if (r_state == GUARD && w_expired) begin
            r_buttons <= r_shift;
            r_valid   <= 1'b1;
         end
      end
   end

endmodule
